fft_frame_scheduler: RTL and testbench
======================================

# fft_frame_scheduler

Schedules audio frames for the tuner FFT. Incoming samples fill two ping-pong sample banks of N words each. When a bank is full and the FFT core is free, the block starts the core on that bank. It then holds the result until the readout side acknowledges it. It sits between the sample front end, the sample-bank RAM, the FFT core's start/done handshake and the MCU readout path.

## Interface
- bit_width, 16, sample word width
- N, 512, samples per frame (power of two)
- M, $clog2(N), bank address width

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- sample_valid  in  1  one new sample this cycle
- sample  in  bit_width  sample data
- wr_en  out  1  sample-bank RAM write strobe
- wr_bank  out  1  bank being written
- wr_adr  out  M  write address
- wr_data  out  bit_width  registered copy of sample
- fft_start  out  1  one-cycle start pulse to FFT core
- fft_bank  out  1  bank the FFT core reads; stable from start until done
- fft_done  in  1  one-cycle completion pulse from FFT core
- result_ready  out  1  level; FFT result valid for readout
- result_ack  in  1  one-cycle pulse; readout finished
- overrun  out  1  sticky; a sample was dropped
- overrun_count  out  8  dropped samples, saturating at 255

## Operation
- Writer side:
  - A sample is accepted when sample_valid=1 and full[wr_bank]=0. Acceptance increments wr_ptr.
  - On accepting the sample at wr_ptr=N-1: set full[wr_bank], toggle wr_bank, wr_ptr←0.
  - sample_valid=1 with full[wr_bank]=1 drops the sample:
    - no write occurs;
    - overrun←1;
    - overrun_count increments, saturating at 255.
- FFT-side state machine (three states):
  - F_IDLE: if full[next_bank]=1, pulse fft_start, set fft_bank←next_bank, go to F_RUN.
  - F_RUN: on fft_done, clear full[fft_bank], set result_ready←1, go to F_HOLD.
  - F_HOLD: on result_ack, clear result_ready, toggle next_bank, go to F_IDLE.
- The bank is released at fft_done because the core has finished reading it. The result lives in core-internal memory, so no new start is issued until it is acknowledged.
- fft_done outside F_RUN and result_ack outside F_HOLD are ignored.
- Simultaneous events:
  - The writer never targets a full bank, so a full-set and a full-clear in the same cycle always hit different banks. Both take effect.
  - Accepting the last sample of a frame and being released by fft_done on the same edge: the writer proceeds into the freed bank with no drop.
- Reset is asynchronous, active-low, and may arrive mid-frame or mid-FFT. The frame in progress is discarded and the block returns to the initial state.

## Timing
- Reset values:
  - all outputs 0;
  - wr_ptr=0, wr_bank=0, next_bank=0;
  - full=2'b00;
  - state F_IDLE.
- Writes are registered. A sample accepted at edge k drives wr_en/wr_adr/wr_data/wr_bank during cycle k+1. wr_adr equals the pre-increment wr_ptr.
- Sustained rate: one sample per cycle, no bubbles at frame boundaries.
- The full flag for a bank sets at the edge that accepts its last sample. fft_start is then high during the following cycle, which is 2 cycles after that sample's valid cycle.
- fft_start lasts exactly 1 cycle.
- result_ready rises 1 cycle after fft_done and falls 1 cycle after result_ack.
- overrun and overrun_count update 1 cycle after the dropped sample.

## Structure
- Shared package fft_pkg holds:
  - fft_sched_state_t enum {F_IDLE, F_RUN, F_HOLD};
  - constants N_FFT=512 and M_FFT=$clog2(N_FFT).
- One sub-module: fft_sample_writer. It owns wr_ptr, wr_bank, the full[1:0] flags, the registered write outputs and the overrun counter. It takes a release strobe and bank index from the FSM in the top level.

## Test plan
- Reset, then 512 back-to-back samples (value = index):
  - wr_adr runs 0..511 on bank 0 with wr_data = index;
  - fft_start pulses 2 cycles after the last valid, with fft_bank=0.
- Continue from the first test:
  - fft_done 100 cycles later → result_ready=1 on the next cycle;
  - result_ack → result_ready=0;
  - a second full frame then starts the core with fft_bank=1.
- Fill bank 0 and bank 1 with no fft_done, then send 300 more samples:
  - wr_en stays 0;
  - overrun=1;
  - overrun_count saturates at 255.
- Bank 1's last sample is accepted on the same cycle as fft_done for bank 0:
  - full becomes 2'b10;
  - after ack, the next start uses fft_bank=1;
  - writing continues at bank 0, adr 0, with no drop.
- Assert reset at wr_adr=200 during F_RUN:
  - all outputs go to 0 immediately;
  - the next sample is written to bank 0, adr 0.
- result_ack in F_IDLE and fft_done in F_HOLD → no state change, no output change.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and FSM state encoding for the FFT frame scheduler.
package fft_pkg;

  localparam int unsigned N_FFT = 512;
  localparam int unsigned M_FFT = $clog2(N_FFT);

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_RUN  = 2'd1,
    F_HOLD = 2'd2
  } fft_sched_state_t;

endpackage

// File: rtl/fft_sample_writer.sv
// Ping-pong sample bank writer: write pointer, bank select, full flags,
// registered RAM write port and the overrun counter.
module fft_sample_writer
  import fft_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned N         = N_FFT,
  parameter int unsigned M         = M_FFT
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_sample_valid,
  input  logic [BIT_WIDTH-1:0] i_sample,
  input  logic                 i_release,
  input  logic                 i_release_bank,
  output logic                 o_wr_en,
  output logic                 o_wr_bank,
  output logic [M-1:0]         o_wr_adr,
  output logic [BIT_WIDTH-1:0] o_wr_data,
  output logic [1:0]           o_full,
  output logic                 o_overrun,
  output logic [7:0]           o_overrun_count
);

  logic [M-1:0]         r_wr_ptr;
  logic                 r_wr_bank;
  logic [1:0]           r_full;
  logic                 r_wr_en;
  logic                 r_wr_bank_q;
  logic [M-1:0]         r_wr_adr;
  logic [BIT_WIDTH-1:0] r_wr_data;
  logic                 r_overrun;
  logic [7:0]           r_ovr_cnt;

  logic                 w_accept;
  logic                 w_drop;
  logic                 w_last;
  logic [1:0]           w_full_nxt;

  assign w_accept = i_sample_valid & ~r_full[r_wr_bank];
  assign w_drop   = i_sample_valid &  r_full[r_wr_bank];
  assign w_last   = (r_wr_ptr == M'(N - 1));

  // Full flags: set on the last accepted sample, cleared by the FSM release;
  // the two never address the same bank in one cycle.
  always_comb begin
    w_full_nxt = r_full;
    if (w_accept && w_last) w_full_nxt[r_wr_bank] = 1'b1;
    if (i_release)          w_full_nxt[i_release_bank] = 1'b0;
  end

  // Write pointer, active bank and full flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr  <= '0;
      r_wr_bank <= 1'b0;
      r_full    <= 2'b00;
    end else begin
      r_full <= w_full_nxt;
      if (w_accept) begin
        r_wr_ptr <= w_last ? '0 : r_wr_ptr + M'(1);
        if (w_last) r_wr_bank <= ~r_wr_bank;
      end
    end
  end

  // Registered RAM write port; address is the pre-increment pointer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_en     <= 1'b0;
      r_wr_bank_q <= 1'b0;
      r_wr_adr    <= '0;
      r_wr_data   <= '0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_wr_bank_q <= r_wr_bank;
        r_wr_adr    <= r_wr_ptr;
        r_wr_data   <= i_sample;
      end
    end
  end

  // Sticky overrun flag and saturating drop counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overrun <= 1'b0;
      r_ovr_cnt <= 8'd0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
      if (r_ovr_cnt != 8'hFF) r_ovr_cnt <= r_ovr_cnt + 8'd1;
    end
  end

  assign o_wr_en         = r_wr_en;
  assign o_wr_bank       = r_wr_bank_q;
  assign o_wr_adr        = r_wr_adr;
  assign o_wr_data       = r_wr_data;
  assign o_full          = r_full;
  assign o_overrun       = r_overrun;
  assign o_overrun_count = r_ovr_cnt;

endmodule

// File: rtl/fft_frame_scheduler.sv
// Starts the FFT core on each full sample bank and holds the result
// until the readout side acknowledges it.
module fft_frame_scheduler
  import fft_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned N         = N_FFT,
  parameter int unsigned M         = $clog2(N)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_sample_valid,
  input  logic [BIT_WIDTH-1:0] i_sample,
  output logic                 o_wr_en,
  output logic                 o_wr_bank,
  output logic [M-1:0]         o_wr_adr,
  output logic [BIT_WIDTH-1:0] o_wr_data,
  output logic                 o_fft_start,
  output logic                 o_fft_bank,
  input  logic                 i_fft_done,
  output logic                 o_result_ready,
  input  logic                 i_result_ack,
  output logic                 o_overrun,
  output logic [7:0]           o_overrun_count
);

  localparam logic [1:0] ST_IDLE = 2'(F_IDLE);
  localparam logic [1:0] ST_RUN  = 2'(F_RUN);
  localparam logic [1:0] ST_HOLD = 2'(F_HOLD);

  logic [1:0] r_state;
  logic       r_fft_start;
  logic       r_fft_bank;
  logic       r_next_bank;
  logic       r_result_ready;

  logic [1:0] w_state_nxt;
  logic       w_start_nxt;
  logic       w_fft_bank_nxt;
  logic       w_next_bank_nxt;
  logic       w_ready_nxt;
  logic       w_release;
  logic [1:0] w_full;

  fft_sample_writer #(
    .BIT_WIDTH (BIT_WIDTH),
    .N         (N),
    .M         (M)
  ) u_writer (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_sample_valid  (i_sample_valid),
    .i_sample        (i_sample),
    .i_release       (w_release),
    .i_release_bank  (r_fft_bank),
    .o_wr_en         (o_wr_en),
    .o_wr_bank       (o_wr_bank),
    .o_wr_adr        (o_wr_adr),
    .o_wr_data       (o_wr_data),
    .o_full          (w_full),
    .o_overrun       (o_overrun),
    .o_overrun_count (o_overrun_count)
  );

  // Next-state and next-output logic; done/ack outside their states are ignored.
  always_comb begin
    w_state_nxt     = r_state;
    w_start_nxt     = 1'b0;
    w_fft_bank_nxt  = r_fft_bank;
    w_next_bank_nxt = r_next_bank;
    w_ready_nxt     = r_result_ready;
    w_release       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_full[r_next_bank]) begin
          w_start_nxt    = 1'b1;
          w_fft_bank_nxt = r_next_bank;
          w_state_nxt    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_fft_done) begin
          w_release   = 1'b1;
          w_ready_nxt = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (i_result_ack) begin
          w_ready_nxt     = 1'b0;
          w_next_bank_nxt = ~r_next_bank;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and registered FSM outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= ST_IDLE;
      r_fft_start    <= 1'b0;
      r_fft_bank     <= 1'b0;
      r_next_bank    <= 1'b0;
      r_result_ready <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_fft_start    <= w_start_nxt;
      r_fft_bank     <= w_fft_bank_nxt;
      r_next_bank    <= w_next_bank_nxt;
      r_result_ready <= w_ready_nxt;
    end
  end

  assign o_fft_start    = r_fft_start;
  assign o_fft_bank     = r_fft_bank;
  assign o_result_ready = r_result_ready;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for fft_frame_scheduler with a write-port scoreboard.
module tb_fft_frame_scheduler;

  typedef struct packed {
    logic        bank;
    logic [8:0]  adr;
    logic [15:0] data;
  } wr_t;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_sample_valid;
  logic [15:0] i_sample;
  logic        o_wr_en;
  logic        o_wr_bank;
  logic [8:0]  o_wr_adr;
  logic [15:0] o_wr_data;
  logic        o_fft_start;
  logic        o_fft_bank;
  logic        i_fft_done;
  logic        o_result_ready;
  logic        i_result_ack;
  logic        o_overrun;
  logic [7:0]  o_overrun_count;

  int   n_tests = 0;
  int   n_fail  = 0;
  wr_t  sb[$];
  logic       m_bank;
  logic [8:0] m_ptr;

  fft_frame_scheduler dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_sample_valid  (i_sample_valid),
    .i_sample        (i_sample),
    .o_wr_en         (o_wr_en),
    .o_wr_bank       (o_wr_bank),
    .o_wr_adr        (o_wr_adr),
    .o_wr_data       (o_wr_data),
    .o_fft_start     (o_fft_start),
    .o_fft_bank      (o_fft_bank),
    .i_fft_done      (i_fft_done),
    .o_result_ready  (o_result_ready),
    .i_result_ack    (i_result_ack),
    .o_overrun       (o_overrun),
    .o_overrun_count (o_overrun_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Drive n consecutive samples; accepted ones are pushed to the scoreboard.
  task automatic send(input int n, input int base, input bit ok, input bit done_last);
    wr_t e;
    for (int i = 0; i < n; i++) begin
      i_sample_valid = 1'b1;
      i_sample       = 16'(base + i);
      if (done_last && (i == n - 1)) i_fft_done = 1'b1;
      if (ok) begin
        e.bank = m_bank;
        e.adr  = m_ptr;
        e.data = 16'(base + i);
        sb.push_back(e);
        if (m_ptr == 9'd511) m_bank = ~m_bank;
        m_ptr = m_ptr + 9'd1;
      end
      tick();
      i_fft_done = 1'b0;
      if (!ok) check("drop_no_write", 32'(o_wr_en), 0);
    end
    i_sample_valid = 1'b0;
  endtask

  // Write-port monitor: every write must match the next scoreboard entry.
  always @(negedge i_clk) begin
    wr_t e;
    if (i_rst_n && o_wr_en) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 32'(o_wr_en), 0);
      end else begin
        e = sb.pop_front();
        check("wr_bank", 32'(o_wr_bank), 32'(e.bank));
        check("wr_adr",  32'(o_wr_adr),  32'(e.adr));
        check("wr_data", 32'(o_wr_data), 32'(e.data));
      end
    end
  end

  initial begin
    i_rst_n        = 1'b0;
    i_sample_valid = 1'b0;
    i_sample       = 16'd0;
    i_fft_done     = 1'b0;
    i_result_ack   = 1'b0;
    m_bank         = 1'b0;
    m_ptr          = 9'd0;
    #1;
    check("rst_wr_en",     32'(o_wr_en), 0);
    check("rst_fft_start", 32'(o_fft_start), 0);
    check("rst_ready",     32'(o_result_ready), 0);
    check("rst_overrun",   32'(o_overrun), 0);
    check("rst_ovr_cnt",   32'(o_overrun_count), 0);
    repeat (2) tick();
    i_rst_n = 1'b1;
    tick();

    // Frame 0: value = index into bank 0, start two cycles after last valid.
    send(512, 0, 1'b1, 1'b0);
    check("t1_start_early", 32'(o_fft_start), 0);
    tick();
    check("t1_start", 32'(o_fft_start), 1);
    check("t1_bank",  32'(o_fft_bank), 0);
    tick();
    check("t1_start_width", 32'(o_fft_start), 0);

    // Done after 100 cycles, ack, then frame 1 starts bank 1.
    repeat (100) tick();
    i_fft_done = 1'b1;
    check("t2_ready_before", 32'(o_result_ready), 0);
    tick();
    i_fft_done = 1'b0;
    check("t2_ready_rise", 32'(o_result_ready), 1);
    i_result_ack = 1'b1;
    tick();
    i_result_ack = 1'b0;
    check("t2_ready_fall", 32'(o_result_ready), 0);
    send(512, 1000, 1'b1, 1'b0);
    check("t2_start_early", 32'(o_fft_start), 0);
    tick();
    check("t2_start", 32'(o_fft_start), 1);
    check("t2_bank",  32'(o_fft_bank), 1);
    tick();

    // Both banks full, then 300 dropped samples.
    send(512, 2000, 1'b1, 1'b0);
    check("t3_overrun_before", 32'(o_overrun), 0);
    send(1, 3000, 1'b0, 1'b0);
    check("t3_overrun",     32'(o_overrun), 1);
    check("t3_ovr_cnt_one", 32'(o_overrun_count), 1);
    send(299, 3001, 1'b0, 1'b0);
    check("t3_overrun_sticky", 32'(o_overrun), 1);
    check("t3_ovr_cnt_sat",    32'(o_overrun_count), 255);

    // Reset, fill bank 0, then finish bank 1 on the fft_done edge.
    i_rst_n = 1'b0;
    #1;
    check("t4_rst_ovr_cnt", 32'(o_overrun_count), 0);
    tick();
    i_rst_n = 1'b1;
    m_bank  = 1'b0;
    m_ptr   = 9'd0;
    tick();
    send(512, 100, 1'b1, 1'b0);
    tick();
    check("t4_start0", 32'(o_fft_start), 1);
    check("t4_bank0",  32'(o_fft_bank), 0);
    send(512, 4000, 1'b1, 1'b1);
    check("t4_full",  32'(dut.u_writer.r_full), 2);
    check("t4_ready", 32'(o_result_ready), 1);
    send(10, 5000, 1'b1, 1'b0);
    check("t4_no_drop", 32'(o_overrun), 0);
    i_result_ack = 1'b1;
    tick();
    i_result_ack = 1'b0;
    check("t4_ready_fall", 32'(o_result_ready), 0);
    check("t4_start_early", 32'(o_fft_start), 0);
    tick();
    check("t4_start1", 32'(o_fft_start), 1);
    check("t4_bank1",  32'(o_fft_bank), 1);

    // Reset at wr_adr=200 while the core runs on bank 1.
    send(191, 6000, 1'b1, 1'b0);
    check("t5_pre_adr", 32'(o_wr_adr), 200);
    @(negedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    check("t5_wr_en",     32'(o_wr_en), 0);
    check("t5_wr_bank",   32'(o_wr_bank), 0);
    check("t5_wr_adr",    32'(o_wr_adr), 0);
    check("t5_wr_data",   32'(o_wr_data), 0);
    check("t5_fft_start", 32'(o_fft_start), 0);
    check("t5_fft_bank",  32'(o_fft_bank), 0);
    check("t5_ready",     32'(o_result_ready), 0);
    check("t5_overrun",   32'(o_overrun), 0);
    check("t5_ovr_cnt",   32'(o_overrun_count), 0);
    check("t5_sb_drained", 32'(sb.size()), 0);
    repeat (2) tick();
    i_rst_n = 1'b1;
    m_bank  = 1'b0;
    m_ptr   = 9'd0;
    tick();
    send(5, 7000, 1'b1, 1'b0);

    // Ack in idle and done in hold must be ignored.
    i_result_ack = 1'b1;
    tick();
    i_result_ack = 1'b0;
    check("t6_idle_ack_ready", 32'(o_result_ready), 0);
    send(507, 7005, 1'b1, 1'b0);
    check("t6_start_early", 32'(o_fft_start), 0);
    tick();
    check("t6_start0", 32'(o_fft_start), 1);
    check("t6_bank0",  32'(o_fft_bank), 0);
    tick();
    i_fft_done = 1'b1;
    tick();
    i_fft_done = 1'b0;
    check("t6_ready", 32'(o_result_ready), 1);
    send(512, 8000, 1'b1, 1'b0);
    tick();
    check("t6_hold_no_start", 32'(o_fft_start), 0);
    i_fft_done = 1'b1;
    tick();
    i_fft_done = 1'b0;
    check("t6_hold_done_ready", 32'(o_result_ready), 1);
    check("t6_hold_done_start", 32'(o_fft_start), 0);
    check("t6_hold_done_bank",  32'(o_fft_bank), 0);
    tick();
    check("t6_hold_still_no_start", 32'(o_fft_start), 0);
    i_result_ack = 1'b1;
    tick();
    i_result_ack = 1'b0;
    check("t6_ready_fall", 32'(o_result_ready), 0);
    tick();
    check("t6_start1", 32'(o_fft_start), 1);
    check("t6_bank1",  32'(o_fft_bank), 1);

    repeat (2) tick();
    check("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
